// File: rtl/datalogger_pkg.sv
//------------------------------------------------------------------------------
// Module   : datalogger_pkg
// Brief    : Register map, bit positions and CONTROL layout for the capture FIFO.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package datalogger_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_DROPS   = 2'd3;

  localparam int ST_EMPTY_BIT   = 16;
  localparam int ST_FULL_BIT    = 17;
  localparam int ST_OVF_BIT     = 18;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_CLR_BIT   = 1;
  localparam int CTRL_IRQEN_BIT = 2;
  localparam int CTRL_THR_LSB   = 8;

  typedef struct packed {
    logic [7:0] threshold;
    logic       irq_en;
    logic       enable;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [31:0] i_word);
    ctrl_t w_c;
    w_c.threshold = i_word[CTRL_THR_LSB +: 8];
    w_c.irq_en    = i_word[CTRL_IRQEN_BIT];
    w_c.enable    = i_word[CTRL_EN_BIT];
    return w_c;
  endfunction

  // Clear is a pulse, so its bit always reads back as zero.
  function automatic logic [31:0] encode_ctrl(input ctrl_t i_c);
    logic [31:0] w_word;
    w_word                      = '0;
    w_word[CTRL_THR_LSB +: 8]   = i_c.threshold;
    w_word[CTRL_IRQEN_BIT]      = i_c.irq_en;
    w_word[CTRL_EN_BIT]         = i_c.enable;
    return w_word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/datalogger_sync_fifo.sv
//------------------------------------------------------------------------------
// Module   : datalogger_sync_fifo
// Brief    : Single-clock FIFO with extra-bit wrap pointers and flush.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module datalogger_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic [LVL_W-1:0] o_level,
  output logic             o_empty,
  output logic             o_full
);

  localparam int IDX_W = LVL_W - 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LVL_W-1:0] r_wptr;
  logic [LVL_W-1:0] r_rptr;
  logic [LVL_W-1:0] w_level;
  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_level = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (w_level == LVL_W'(DEPTH));

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !w_empty && !i_flush;
  assign w_do_push = i_push && (!w_full || w_do_pop) && !i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[IDX_W-1:0]] <= i_din;
  end

  assign o_dout  = r_mem[r_rptr[IDX_W-1:0]];
  assign o_level = w_level;
  assign o_empty = w_empty;
  assign o_full  = w_full;

endmodule

`default_nettype wire

// File: rtl/datalogger_capture_fifo.sv
//------------------------------------------------------------------------------
// Module   : datalogger_capture_fifo
// Brief    : Timestamped sample capture FIFO behind an Avalon-MM slave window.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module datalogger_capture_fifo
  import datalogger_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 64,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              irq
);

  ctrl_t             r_ctrl;
  logic [TS_W-1:0]   r_ts;
  logic [15:0]       r_drops;
  logic              r_ovf;
  logic [31:0]       r_rdata;
  logic              r_rdv;
  logic              r_irq;

  logic [31:0]       w_dout;
  logic [LVL_W-1:0]  w_level;
  logic              w_empty;
  logic              w_full;
  logic              w_rd_data;
  logic              w_wr_ctrl;
  logic              w_wr_status;
  logic              w_clear;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [31:0]       w_status;
  logic [31:0]       w_rd_mux;
  logic [15:0]       w_level16;
  logic [15:0]       w_thr16;

  assign w_rd_data   = avs_read && (avs_address == ADDR_DATA);
  assign w_wr_ctrl   = avs_write && (avs_address == ADDR_CONTROL);
  assign w_wr_status = avs_write && (avs_address == ADDR_STATUS);
  assign w_clear     = w_wr_ctrl && avs_writedata[CTRL_CLR_BIT];

  // Clear beats a same-cycle sample, so the push is suppressed outright.
  assign w_pop  = w_rd_data && !w_empty;
  assign w_push = sample_valid && r_ctrl.enable && !w_clear;
  assign w_drop = w_push && w_full && !w_pop;

  datalogger_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_clear),
    .i_din   ({r_ts, sample_data}),
    .o_dout  (w_dout),
    .o_level (w_level),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign w_level16 = 16'(w_level);
  assign w_thr16   = {8'h00, r_ctrl.threshold};

  always_comb begin
    w_status               = '0;
    w_status[15:0]         = w_level16;
    w_status[ST_EMPTY_BIT] = w_empty;
    w_status[ST_FULL_BIT]  = w_full;
    w_status[ST_OVF_BIT]   = r_ovf;
  end

  always_comb begin
    w_rd_mux = '0;
    case (avs_address)
      ADDR_DATA:    w_rd_mux = w_empty ? 32'h0 : w_dout;
      ADDR_STATUS:  w_rd_mux = w_status;
      ADDR_CONTROL: w_rd_mux = encode_ctrl(r_ctrl);
      ADDR_DROPS:   w_rd_mux = {16'h0000, r_drops};
      default:      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_ctrl  <= '0;
      r_ts    <= '0;
      r_drops <= '0;
      r_ovf   <= 1'b0;
      r_rdata <= '0;
      r_rdv   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_rdv <= avs_read;
      if (avs_read) r_rdata <= w_rd_mux;

      if (w_wr_ctrl) r_ctrl <= decode_ctrl(avs_writedata);

      if (w_clear)             r_ts <= '0;
      else if (r_ctrl.enable)  r_ts <= r_ts + 1'b1;

      if (w_clear)                          r_drops <= '0;
      else if (w_drop && r_drops != 16'hFFFF) r_drops <= r_drops + 16'd1;

      // A drop in the same cycle as a clear-overflow write keeps the flag set.
      if (w_clear)                                       r_ovf <= 1'b0;
      else if (w_drop)                                   r_ovf <= 1'b1;
      else if (w_wr_status && avs_writedata[ST_OVF_BIT]) r_ovf <= 1'b0;

      r_irq <= r_ctrl.irq_en && (r_ctrl.threshold != 8'h00) && (w_level16 >= w_thr16);
    end
  end

  assign avs_readdata      = r_rdata;
  assign avs_readdatavalid = r_rdv;
  assign irq               = r_irq;

endmodule

`default_nettype wire

// File: doc/datalogger_capture_fifo.md
# datalogger_capture_fifo

Fabric-side Avalon-MM responder for the datalogger. It timestamps and buffers ADC/sensor samples arriving from FPGA logic in an on-chip FIFO. The HPS lightweight bridge (initiator) drains them through a four-register slave window and can be interrupted on a fill threshold. It complements the HPS-to-fabric system: that system initiates reads, and this block answers them.

## Interface
- DATA_W, 16, sample width; DATA_W + TS_W must equal 32.
- TS_W, 16, timestamp width.
- DEPTH, 64, FIFO entries; power of two, 4..256.
- LVL_W, $clog2(DEPTH)+1, level counter width (derived).

- clk_clk  in  1  single system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- sample_data  in  DATA_W  sample from the acquisition logic.
- sample_valid  in  1  one-cycle qualifier; there is no backpressure.
- avs_address  in  2  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data.
- avs_readdatavalid  out  1  read data qualifier.
- irq  out  1  level-sensitive interrupt.

## Operation
- **Timestamp**
  - ts is a free-running TS_W counter.
  - It increments every cycle while CONTROL.enable=1, holds while enable=0, and wraps from all-ones to 0.
- **Capture**
  - On sample_valid && enable, push {ts, sample_data}, with ts in bits [31:DATA_W].
  - If the FIFO is full and no pop occurs in the same cycle, the sample is dropped:
    - overflow (sticky) is set;
    - drops increments, saturating at 0xFFFF.
  - Samples are ignored while enable=0.
- **Register map** (word addresses)
  - 0 DATA, read-only.
    - Read when not empty: returns the head entry and pops it.
    - Read when empty: returns 0 with no pop and no state change.
  - 1 STATUS
    - Read: [15:0] level, zero-extended; [16] empty; [17] full; [18] overflow; other bits 0.
    - Write: writedata[18]=1 clears overflow; all other bits are ignored.
  - 2 CONTROL, read/write.
    - [0] enable; [2] irq_en; [15:8] threshold.
    - [1] clear: write-1 pulse that always reads 0. It flushes the FIFO and zeroes ts, drops and overflow.
  - 3 DROPS: read returns {16'b0, drops}; writes are ignored.
- **Interrupt:** irq = irq_en && threshold != 0 && level >= threshold. It is registered.
- **Simultaneous events**
  - Push and pop in the same cycle when full: both occur, level is unchanged, no overflow.
  - Push and DATA read in the same cycle when empty: the read returns 0 and the push is stored. There is no bypass.
  - Clear with a same-cycle push: clear wins and the sample is discarded.
  - The initiator never asserts avs_read and avs_write together. Behaviour in that case is unspecified.

## Timing
- **Read latency** is fixed at 1 cycle.
  - avs_readdata and avs_readdatavalid are registered and valid the cycle after avs_read.
  - There is no waitrequest.
  - avs_readdata holds its last value when avs_readdatavalid=0.
- **Write effect:** a write takes effect on the next clock edge. Clear completes in that edge: level=0, empty=1 the following cycle.
- **Push visibility:** a push at edge N makes level and empty visible to a STATUS read issued at cycle N. The data returns at N+1.
- **FIFO storage:** registered; the pop result appears on readdata in the same latency-1 slot.
- **Reset values:** avs_readdata=0, avs_readdatavalid=0, irq=0, enable=0, irq_en=0, threshold=0, ts=0, drops=0, overflow=0, FIFO empty.
- **Mid-operation reset:** reset asserted mid-operation takes effect immediately (asynchronous) and discards a pending read response.

## Structure
- Package datalogger_pkg holds:
  - register address constants (ADDR_DATA=0, ADDR_STATUS=1, ADDR_CONTROL=2, ADDR_DROPS=3);
  - STATUS/CONTROL bit-position constants;
  - a packed struct for CONTROL.
- Sub-module datalogger_sync_fifo: single-clock FIFO with
  - inputs push, pop, flush;
  - outputs dout, level, empty, full;
  - wrap-around read/write pointers with one extra bit for full/empty detection.
- The top level contains the timestamp counter, drop counter, register decode, read-response pipeline and irq.

## Test plan
- Reset, then read STATUS -> 0x0001_0000 (empty). Read CONTROL -> 0. Read DATA -> 0. irq=0.
- Enable, push samples 0x1111 and 0x2222 three cycles apart, then read DATA twice -> the upper halves differ by 3, the lower halves are 0x1111 then 0x2222, and the FIFO is empty afterwards.
- Push DEPTH+5 samples with no reads -> full=1, overflow=1, DROPS=5. Write STATUS 0x0004_0000 -> overflow=0.
- Fill to full, then push and DATA-read in the same cycle -> level stays DEPTH, drops unchanged, the oldest entry is returned.
- Set threshold=4 and irq_en=1, push 4 samples -> irq rises the cycle after level reaches 4. One DATA read -> irq falls.
- Write CONTROL clear with a same-cycle sample_valid -> level=0, ts restarts at 0, drops=0. Assert reset during an outstanding read -> readdatavalid=0.
